// File: rtl/mips32_arb_pkg.sv
// Shared types and defaults for the MIPS32 instruction/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips32_arb_pkg;

  localparam int ARB_AW         = 9;   // 512-word memory
  localparam int ARB_DW         = 32;
  localparam int ARB_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mips32_arb_stats.sv
// Arbiter statistics: IDLE-cycle fetch/data conflicts and forced fetch wins.
// Latency: counters update on the edge after the qualifying cycle.
// Backpressure: none; both counters free-run and wrap at 2^32.
module mips32_arb_stats
  import mips32_arb_pkg::*;
(
  input  logic              clk1,
  input  logic              rst,
  input  logic              conflict_i,
  input  logic              starve_i,
  output logic [ARB_DW-1:0] conflict_cnt_o,
  output logic [ARB_DW-1:0] starve_cnt_o
);

  logic [ARB_DW-1:0] conflict_q, conflict_d;
  logic [ARB_DW-1:0] starve_q, starve_d;

  // Next-state: bump each counter on its event, natural wrap.
  always_comb begin
    conflict_d = conflict_q + (conflict_i ? 32'd1 : 32'd0);
    starve_d   = starve_q   + (starve_i   ? 32'd1 : 32'd0);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      conflict_q <= '0;
      starve_q   <= '0;
    end else begin
      conflict_q <= conflict_d;
      starve_q   <= starve_d;
    end
  end

  assign conflict_cnt_o = conflict_q;
  assign starve_cnt_o   = starve_q;

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory; MIPS32_ARB_STATS_EN builds stat counters.
// Latency: grant in cycle 0, mem_req from cycle 1 until mem_ready, response pulse the cycle after.
// Backpressure: grants only in IDLE; data wins unless fetch starved STARVE_MAX times; halt blocks fetch grants.
module mips32_mem_arbiter
  import mips32_arb_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX,
  parameter int AW         = ARB_AW
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [ARB_DW-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [AW-1:0]     dm_addr,
  input  logic [ARB_DW-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [ARB_DW-1:0] dm_rdata,
  input  logic              halt,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [ARB_DW-1:0] mem_wdata,
  input  logic [ARB_DW-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ARB_DW-1:0] stat_conflict,
  output logic [ARB_DW-1:0] stat_starve
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  arb_state_e        state_q;
  logic [3:0]        starve_q;
  logic              drop_q;
  logic [AW-1:0]     addr_q;
  logic              we_q;
  logic [ARB_DW-1:0] wdata_q;
  logic              mem_req_q;
  logic              if_rvalid_q, dm_done_q;
  logic [ARB_DW-1:0] if_rdata_q, dm_rdata_q;

  logic in_idle, if_ok, force_if, if_gnt_d, dm_gnt_d;

  // Grant decode; reset is folded in so grants read 0 while rst is low.
  always_comb begin
    in_idle  = (state_q == IDLE) && rst;
    if_ok    = if_req && !halt;
    force_if = (starve_q == SMAX) && if_ok;
    dm_gnt_d = in_idle && dm_req && !force_if;
    if_gnt_d = in_idle && if_ok && !dm_gnt_d;
  end

  // Main FSM: latch request, hold memory access until ready, one-cycle response.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      mem_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dm_gnt_d) begin
            addr_q    <= dm_addr;
            we_q      <= dm_we;
            wdata_q   <= dm_wdata;
            mem_req_q <= 1'b1;
            state_q   <= BUSY_DM;
          end else if (if_gnt_d) begin
            addr_q    <= if_addr;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            mem_req_q <= 1'b1;
            drop_q    <= flush;
            state_q   <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          // The access always completes; a flush only hides its result.
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            drop_q    <= 1'b0;
            state_q   <= RESP;
            if (!(drop_q || flush)) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            dm_done_q <= 1'b1;
            state_q   <= RESP;
            if (!we_q) dm_rdata_q <= mem_rdata;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Starve counter: counts data wins over a waiting fetch, saturating at the limit.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (if_gnt_d || !if_req) starve_q <= '0;
      else if (dm_gnt_d && starve_q != SMAX) starve_q <= starve_q + 4'd1;
    end
  end

  assign if_gnt    = if_gnt_d;
  assign dm_gnt    = dm_gnt_d;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_done   = dm_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef MIPS32_ARB_STATS_EN
  logic conflict_ev, starve_ev;
  // A forced win is a fetch grant taken while data was also requesting.
  assign conflict_ev = in_idle && if_req && dm_req;
  assign starve_ev   = if_gnt_d && dm_req;

  mips32_arb_stats u_stats (
    .clk1           (clk1),
    .rst            (rst),
    .conflict_i     (conflict_ev),
    .starve_i       (starve_ev),
    .conflict_cnt_o (stat_conflict),
    .starve_cnt_o   (stat_starve)
  );
`else
  assign stat_conflict = '0;
  assign stat_starve   = '0;
`endif

endmodule
